// File: rtl/accum_master_engine.sv
// accum_master_engine: job-driven initiator for the accumulator subsystem.
// Write jobs stream beats out as per-row write commands plus write data.
// Read jobs issue row reads under a credit limit and return the data through
// a small FIFO.
// Optional macro ACCUM_MASTER_PERF_EN enables the stall_cycles counter.
module accum_master_engine #(
  parameter int NUM_BANKS    = 4,
  parameter int ADDR_WIDTH   = 9,
  parameter int DATA_WIDTH   = 64,
  parameter int ZONE_WIDTH   = 2,
  parameter int LEN_WIDTH    = 10,
  parameter int RD_BUF_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            job_valid,
  output logic                            job_ready,
  input  logic                            job_op,
  input  logic [ZONE_WIDTH-1:0]           job_zone,
  input  logic [ADDR_WIDTH-1:0]           job_addr,
  input  logic [LEN_WIDTH-1:0]            job_len,
  input  logic [NUM_BANKS-1:0]            job_mask,
  input  logic                            job_accum,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] s_data,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] m_data,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     stall_cycles,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ZONE_WIDTH-1:0]           wr_zone_id,
  output logic [ADDR_WIDTH-1:0]           wr_addr,
  output logic [NUM_BANKS-1:0]            wr_mask,
  output logic                            accum_en,
  output logic                            rd_valid,
  input  logic                            rd_ready,
  output logic [ZONE_WIDTH-1:0]           rd_zone_id,
  output logic [ADDR_WIDTH-1:0]           rd_addr,
  output logic [NUM_BANKS-1:0]            rd_mask,
  output logic                            wvalid,
  input  logic                            wready,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] wdata,
  input  logic                            rvalid,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] rdata
);

  localparam int BW = NUM_BANKS*DATA_WIDTH;
  localparam int PW = $clog2(RD_BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RD_BUF_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state;
  logic [ZONE_WIDTH-1:0] zone_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [NUM_BANKS-1:0]  mask_q;
  logic                  accum_q;
  logic [LEN_WIDTH-1:0]  cc, dc, ic, rc;
  logic [CW-1:0]         outst, fcnt;
  logic [PW-1:0]         wptr, rptr;
  logic [BW-1:0]         mem [RD_BUF_DEPTH];

  logic in_wr, in_rd, accept;
  logic wr_xfer, w_xfer, rd_xfer, rd_pend, credit_ok;
  logic fifo_full, fifo_empty, pop, ret, push;

  assign in_wr  = (state == S_WRITE);
  assign in_rd  = (state == S_READ);
  // job_ready is also gated by rstn so every output reads 0 during reset
  assign job_ready = rstn && (state == S_IDLE);
  assign accept    = job_valid && job_ready;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  // write channel: command and data run on independent counters
  assign wr_valid   = in_wr && (cc < len_q);
  assign wr_addr    = base_q + ADDR_WIDTH'(cc);
  assign wr_zone_id = zone_q;
  assign wr_mask    = mask_q;
  assign accum_en   = accum_q;
  assign wvalid     = in_wr && s_valid && (dc < len_q);
  assign s_ready    = in_wr && wready && (dc < len_q);
  assign wdata      = in_wr ? s_data : '0;
  assign wr_xfer    = wr_valid && wr_ready;
  assign w_xfer     = wvalid && wready;

  // read channel: in-flight reads plus buffered beats never exceed the FIFO depth
  assign fifo_full  = (fcnt == DEPTH_C);
  assign fifo_empty = (fcnt == '0);
  assign credit_ok  = (outst + fcnt) < DEPTH_C;
  assign rd_pend    = in_rd && (ic < len_q);
  assign rd_valid   = rd_pend && credit_ok;
  assign rd_addr    = base_q + ADDR_WIDTH'(ic);
  assign rd_zone_id = zone_q;
  assign rd_mask    = mask_q;
  assign rd_xfer    = rd_valid && rd_ready;
  assign m_valid    = in_rd && !fifo_empty;
  assign m_data     = m_valid ? mem[rptr] : '0;
  assign pop        = m_valid && m_ready;
  assign ret        = rvalid && in_rd;
  // a pop in the same cycle frees the slot, so a push into a full FIFO is fine then
  assign push       = ret && (!fifo_full || pop);

  // job sequencing, counters and FIFO bookkeeping
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      zone_q  <= '0;
      base_q  <= '0;
      len_q   <= '0;
      mask_q  <= '0;
      accum_q <= 1'b0;
      cc      <= '0;
      dc      <= '0;
      ic      <= '0;
      rc      <= '0;
      outst   <= '0;
      fcnt    <= '0;
      wptr    <= '0;
      rptr    <= '0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          zone_q  <= job_zone;
          base_q  <= job_addr;
          len_q   <= job_len;
          mask_q  <= job_mask;
          accum_q <= job_accum;
          cc      <= '0;
          dc      <= '0;
          ic      <= '0;
          rc      <= '0;
          outst   <= '0;
          fcnt    <= '0;
          wptr    <= '0;
          rptr    <= '0;
          if (job_len == '0) state <= S_DONE;
          else               state <= job_op ? S_READ : S_WRITE;
        end
        S_WRITE: begin
          if (wr_xfer) cc <= cc + LEN_WIDTH'(1);
          if (w_xfer)  dc <= dc + LEN_WIDTH'(1);
          if ((cc == len_q) && (dc == len_q)) state <= S_DONE;
        end
        S_READ: begin
          if (rd_xfer) ic <= ic + LEN_WIDTH'(1);
          if (ret)     rc <= rc + LEN_WIDTH'(1);
          case ({rd_xfer, ret})
            2'b10:   outst <= outst + CW'(1);
            2'b01:   outst <= outst - CW'(1);
            default: outst <= outst;
          endcase
          case ({push, pop})
            2'b10:   fcnt <= fcnt + CW'(1);
            2'b01:   fcnt <= fcnt - CW'(1);
            default: fcnt <= fcnt;
          endcase
          if (push) wptr <= wptr + PW'(1);
          if (pop)  rptr <= rptr + PW'(1);
          if ((rc == len_q) && fifo_empty) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // return-data storage; contents are don't-care while empty, m_data is gated
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= rdata;
  end

`ifdef ACCUM_MASTER_PERF_EN
  logic [31:0] stall_q;
  logic        stall_hit;
  assign stall_hit = (wr_valid && !wr_ready) || (wvalid && !wready) ||
                     (rd_valid && !rd_ready) || (rd_pend && !credit_ok);
  // per-job stall counter, saturating, held after completion
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                   stall_q <= '0;
    else if (accept)                             stall_q <= '0;
    else if (stall_hit && (stall_q != '1))       stall_q <= stall_q + 32'd1;
  end
  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

`ifndef SYNTHESIS
  // read returns are only legal in READ and only when the FIFO can take them
  rvalid_legal: assert property (@(posedge clk) disable iff (!rstn)
    rvalid |-> (in_rd && (!fifo_full || pop)));
`endif

endmodule
